// File: rtl/disp_scan_if.sv
// Segment-code inputs and multiplexed display drive for the 4-digit scanner.
interface disp_scan_if;
  logic [6:0] bcd_3_bus;
  logic [6:0] bcd_2_bus;
  logic [6:0] bcd_1_bus;
  logic [6:0] bcd_0_bus;
  logic       lzb_en;
  logic       dp_en;
  logic [1:0] dp_pos;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output bcd_3_bus, bcd_2_bus, bcd_1_bus, bcd_0_bus, lzb_en, dp_en, dp_pos,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  bcd_3_bus, bcd_2_bus, bcd_1_bus, bcd_0_bus, lzb_en, dp_en, dp_pos,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/disp_scan.sv
// Common-anode 4-digit scanner: frame-latched inputs, dead time between digits,
// leading-zero blanking and decimal point; all outputs registered.
module disp_scan #(
  parameter int         DIGIT_CYCLES = 25,
  parameter int         DEAD_CYCLES  = 2,
  parameter logic [6:0] ZERO_PATTERN = 7'b0111111
) (
  input  logic        clk_sistema_100k,
  input  logic        reset_sistema,
  disp_scan_if.slave  bus
);

  localparam int CNT_MAX = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic {ST_DEAD, ST_ON} state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [3:0][6:0]  sh_bus;
  logic             sh_lzb;
  logic             sh_dp_en;
  logic [1:0]       sh_dp_pos;

  logic             frame_ld;
  logic [3:0]       an_p0;
  logic [6:0]       seg_p0;
  logic             dp_p0;

  logic [3:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             dp_p1;
  logic             frame_start_p1;

  // Digit k blanks only if it and every more significant digit read as zero
  // and no decimal point is lit at or above it; digit 0 always shows.
  function automatic logic blank_digit(input logic [1:0] k,
                                       input logic [3:0][6:0] b,
                                       input logic lzb,
                                       input logic dpe,
                                       input logic [1:0] dpp);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(k) && b[j] != ZERO_PATTERN) all_zero = 1'b0;
    end
    return lzb && (k != 2'd0) && all_zero && !(dpe && (dpp >= k));
  endfunction

  always_ff @(posedge clk_sistema_100k) begin
    if (reset_sistema) begin
      state <= ST_DEAD;
      idx   <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      ST_DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end
      end
      ST_ON: begin
        if (cnt == DIG_LAST) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = '0;
          idx_nxt   = idx - 2'd1;
        end
      end
      default: begin
        state_nxt = ST_DEAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign frame_ld = (state == ST_DEAD) && (idx == 2'd3) && (cnt == '0);

  always_ff @(posedge clk_sistema_100k) begin
    if (reset_sistema) begin
      sh_bus    <= '0;
      sh_lzb    <= 1'b0;
      sh_dp_en  <= 1'b0;
      sh_dp_pos <= 2'd0;
    end else if (frame_ld) begin
      sh_bus    <= {bus.bcd_3_bus, bus.bcd_2_bus, bus.bcd_1_bus, bus.bcd_0_bus};
      sh_lzb    <= bus.lzb_en;
      sh_dp_en  <= bus.dp_en;
      sh_dp_pos <= bus.dp_pos;
    end
  end

  // p0: decode the current slot from state and shadowed frame data
  always_comb begin
    an_p0  = 4'b1111;
    seg_p0 = 7'b1111111;
    dp_p0  = 1'b1;
    if (state == ST_ON) begin
      an_p0[idx] = 1'b0;
      if (!blank_digit(idx, sh_bus, sh_lzb, sh_dp_en, sh_dp_pos)) seg_p0 = ~sh_bus[idx];
      dp_p0 = ~(sh_dp_en && (sh_dp_pos == idx));
    end
  end

  // p1: registered drive, anode and segments move on the same edge
  always_ff @(posedge clk_sistema_100k) begin
    if (reset_sistema) begin
      an_p1          <= 4'b1111;
      seg_p1         <= 7'b1111111;
      dp_p1          <= 1'b1;
      frame_start_p1 <= 1'b0;
    end else begin
      an_p1          <= an_p0;
      seg_p1         <= seg_p0;
      dp_p1          <= dp_p0;
      frame_start_p1 <= frame_ld;
    end
  end

  assign bus.an          = an_p1;
  assign bus.seg         = seg_p1;
  assign bus.dp          = dp_p1;
  assign bus.frame_start = frame_start_p1;

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: table of frame vectors checked cycle by cycle through an
// expectation queue, plus mid-frame input change and mid-slot reset sequences.
module tb_disp_scan;

  localparam int DIG   = 25;
  localparam int DEAD  = 2;
  localparam int SLOT  = DIG + DEAD;
  localparam int FRAME = 4 * SLOT;

  logic clk_sistema_100k = 1'b0;
  logic reset_sistema    = 1'b1;

  disp_scan_if bus ();

  disp_scan dut (
    .clk_sistema_100k (clk_sistema_100k),
    .reset_sistema    (reset_sistema),
    .bus              (bus.slave)
  );

  always #5 clk_sistema_100k = ~clk_sistema_100k;

  typedef struct packed {
    logic [6:0] b3, b2, b1, b0;
    logic       lzb, dpe;
    logic [1:0] dpp;
    logic [6:0] s3, s2, s1, s0;
    logic [3:0] dpx;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[7];

  function automatic obs_t model(input int n, input vec_t v);
    obs_t o;
    int   p, q, d;
    p = n % FRAME;
    q = p % SLOT;
    d = 3 - p / SLOT;
    o.an  = 4'b1111;
    o.seg = 7'b1111111;
    o.dp  = 1'b1;
    o.fs  = (p == 0);
    if (q >= DEAD) begin
      o.an[d] = 1'b0;
      case (d)
        3: o.seg = v.s3;
        2: o.seg = v.s2;
        1: o.seg = v.s1;
        default: o.seg = v.s0;
      endcase
      o.dp = v.dpx[d];
    end
    return o;
  endfunction

  task automatic apply_vec(input vec_t v);
    bus.bcd_3_bus = v.b3;
    bus.bcd_2_bus = v.b2;
    bus.bcd_1_bus = v.b1;
    bus.bcd_0_bus = v.b0;
    bus.lzb_en    = v.lzb;
    bus.dp_en     = v.dpe;
    bus.dp_pos    = v.dpp;
  endtask

  task automatic compare(input string name, input obs_t e);
    obs_t a;
    a = {bus.an, bus.seg, bus.dp, bus.frame_start};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
               name, a.an, a.seg, a.dp, a.fs, e.an, e.seg, e.dp, e.fs);
    end
  endtask

  task automatic check_reset_state(input string name);
    compare(name, obs_t'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
  endtask

  // Push the expectation for cycle n, then compare once the DUT has produced it
  task automatic step_check(input string name, input int n, input vec_t v);
    obs_t e;
    exp_q.push_back(model(n, v));
    @(negedge clk_sistema_100k);
    e = exp_q.pop_front();
    compare($sformatf("%s cyc%0d", name, n), e);
  endtask

  task automatic reset_and_load(input vec_t v);
    reset_sistema = 1'b1;
    repeat (2) @(negedge clk_sistema_100k);
    check_reset_state("reset_hold");
    apply_vec(v);
    reset_sistema = 1'b0;
  endtask

  initial begin
    vec_t v, vn;

    //           b3     b2     b1     b0     lzb   dpe   dpp    s3     s2     s1     s0     dpx
    tbl[0] = '{7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 2'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111};
    tbl[1] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, 1'b0, 2'd0, 7'h79, 7'h24, 7'h30, 7'h19, 4'b1111};
    tbl[2] = '{7'h3F, 7'h3F, 7'h66, 7'h5B, 1'b1, 1'b0, 2'd0, 7'h7F, 7'h7F, 7'h19, 7'h24, 4'b1111};
    tbl[3] = '{7'h3F, 7'h3F, 7'h66, 7'h5B, 1'b1, 1'b1, 2'd2, 7'h7F, 7'h40, 7'h19, 7'h24, 4'b1011};
    tbl[4] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1, 1'b0, 2'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111};
    tbl[5] = '{7'h3F, 7'h3F, 7'h3F, 7'h06, 1'b1, 1'b1, 2'd0, 7'h7F, 7'h7F, 7'h7F, 7'h79, 4'b1110};
    tbl[6] = '{7'h3F, 7'h3F, 7'h06, 7'h5B, 1'b1, 1'b1, 2'd3, 7'h40, 7'h40, 7'h79, 7'h24, 4'b0111};

    apply_vec(tbl[0]);
    repeat (3) @(negedge clk_sistema_100k);
    check_reset_state("reset_initial");

    for (int i = 0; i < 7; i++) begin
      reset_and_load(tbl[i]);
      for (int n = 0; n < ((i == 0) ? FRAME + 4 : FRAME); n++)
        step_check($sformatf("vec%0d", i), n, tbl[i]);
    end

    // Input change during the digit-1 slot only shows after the next frame latch
    v = tbl[1];
    reset_and_load(v);
    for (int n = 0; n < 60; n++) step_check("midchg_old", n, v);
    bus.bcd_3_bus = 7'h6D;
    vn = v;
    vn.b3 = 7'h6D;
    vn.s3 = 7'h12;
    for (int n = 60; n < FRAME; n++) step_check("midchg_hold", n, v);
    for (int n = FRAME; n < FRAME + 30; n++) step_check("midchg_new", n, vn);

    // One-cycle reset inside the digit-2 ON slot
    v = tbl[1];
    reset_and_load(v);
    for (int n = 0; n < 40; n++) step_check("midrst_pre", n, v);
    reset_sistema = 1'b1;
    @(negedge clk_sistema_100k);
    check_reset_state("midrst_assert");
    reset_sistema = 1'b0;
    for (int n = 0; n < 35; n++) step_check("midrst_post", n, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
